round_key_generator: RTL and testbench

ROUND_KEY_GENERATOR -- requirements
Module: round_key_generator

---
 rtl/des_key_pkg.sv | 56 +++++
 rtl/key_round_step.sv | 34 +++
 rtl/round_key_generator.sv | 185 ++++++++++++++++++
 tb/tb_round_key_generator.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_key_pkg.sv
`default_nettype none
// ============================================================================
// Module      : des_key_pkg
// Description : Shared DES key-schedule constants: widths, round count, the
//               per-round left-rotate amounts and the PC2 selection table,
//               plus the PC2 helper used on the registered C/D pair.
//               Build option KEY_SCHED_DECRYPT_EN (used by the top level)
//               does not change this package.
// Revision    : 1.0  initial release
// ============================================================================
package des_key_pkg;

    localparam int SUBKEY_W   = 48;
    localparam int CD_W       = 56;
    localparam int HALF_W     = 28;
    localparam int NUM_ROUNDS = 16;

    // Schedule FSM: a schedule is either in progress or not.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Left-rotate amount applied to produce round r+1 (index = round - 1).
    localparam logic [1:0] SHIFT_TABLE [NUM_ROUNDS] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // PC2 in the usual DES numbering: entry i names the 1-based bit of {C,D}
    // (bit 1 = MSB) that becomes subkey bit i+1 (bit 1 = MSB).
    localparam logic [5:0] PC2_TABLE [SUBKEY_W] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    function automatic logic [SUBKEY_W-1:0] pc2(input logic [CD_W-1:0] cd);
        logic [SUBKEY_W-1:0] k;
        logic [5:0]          pos;
        k = '0;
        for (int i = 0; i < SUBKEY_W; i++) begin
            // 1-based MSB-first numbering converted to a vector index.
            pos = 6'(CD_W) - PC2_TABLE[i];
            k[SUBKEY_W-1-i] = cd[pos];
        end
        return k;
    endfunction

endpackage : des_key_pkg
`default_nettype wire

// File: rtl/key_round_step.sv
`default_nettype none
// ============================================================================
// Module      : key_round_step
// Description : Combinational one-round step of the DES key schedule: rotates
//               the C and D halves left, independently, by 1 or 2 bits.
// Ports       : i_cd    [55:0] {C[27:0], D[27:0]} before the step
//               i_shift [1:0]  rotate amount (2 -> by two, otherwise by one)
//               o_cd    [55:0] {C, D} after the step
// Revision    : 1.0  initial release
// ============================================================================
module key_round_step
    import des_key_pkg::*;
(
    input  logic [CD_W-1:0] i_cd,
    input  logic [1:0]      i_shift,
    output logic [CD_W-1:0] o_cd
);

    logic [HALF_W-1:0] w_c;
    logic [HALF_W-1:0] w_d;

    assign w_c = i_cd[CD_W-1:HALF_W];
    assign w_d = i_cd[HALF_W-1:0];

    always_comb begin
        o_cd = {w_c[HALF_W-2:0], w_c[HALF_W-1], w_d[HALF_W-2:0], w_d[HALF_W-1]};
        if (i_shift == 2'd2) begin
            o_cd = {w_c[HALF_W-3:0], w_c[HALF_W-1:HALF_W-2],
                    w_d[HALF_W-3:0], w_d[HALF_W-1:HALF_W-2]};
        end
    end

endmodule : key_round_step
`default_nettype wire

// File: rtl/round_key_generator.sv
`default_nettype none
// ============================================================================
// Module      : round_key_generator
// Description : Sequential DES round-key generator. An accepted start loads
//               the PC1-permuted key; the 16 subkeys are then offered one per
//               cycle on a valid/ready handshake, and done pulses once after
//               the final handshake.
// Ports       : clk, rst (sync, active-high)
//               start, pc1_key[55:0]           schedule request (IDLE only)
//               decrypt                        K16-first order (option only)
//               busy                           schedule in progress
//               subkey_valid/subkey_ready      output handshake
//               subkey[47:0], round_idx[3:0]   PC2({C,D}), round - 1
//               last, done                     final subkey / completion pulse
// Option      : KEY_SCHED_DECRYPT_EN adds the decrypt port and right-rotate
//               path; undefined builds encrypt order only.
// Revision    : 1.0  initial release
// ============================================================================
module round_key_generator
    import des_key_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CD_W-1:0]     pc1_key,
`ifdef KEY_SCHED_DECRYPT_EN
    input  logic                decrypt,
`endif
    input  logic                subkey_ready,
    output logic                busy,
    output logic                subkey_valid,
    output logic [SUBKEY_W-1:0] subkey,
    output logic [3:0]          round_idx,
    output logic                last,
    output logic                done
);

    localparam logic [3:0] c_idx_max = 4'(NUM_ROUNDS - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [CD_W-1:0] r_cd;
    logic [3:0]      r_round_idx;
    logic            r_valid;
    logic            r_done;

    logic            w_handshake;
    logic            w_at_end;
    logic            w_load;
    logic            w_advance;
    logic            w_finish;
    logic [3:0]      w_idx_inc;
    logic [CD_W-1:0] w_step_in;
    logic [1:0]      w_step_shift;
    logic [CD_W-1:0] w_step_out;

`ifdef KEY_SCHED_DECRYPT_EN
    logic            r_decrypt;
    logic [CD_W-1:0] w_cd_right;
`endif

    assign w_handshake = r_valid & subkey_ready;
    assign w_idx_inc   = r_round_idx + 4'd1;

`ifdef KEY_SCHED_DECRYPT_EN
    assign w_at_end = r_decrypt ? (r_round_idx == 4'd0) : (r_round_idx == c_idx_max);
`else
    assign w_at_end = (r_round_idx == c_idx_max);
`endif

    // In IDLE the rotator forms round 1 from the incoming key; in RUN it
    // forms the following round from the registered pair.
    assign w_step_in    = (r_state == ST_IDLE) ? pc1_key : r_cd;
    assign w_step_shift = (r_state == ST_IDLE) ? SHIFT_TABLE[0] : SHIFT_TABLE[w_idx_inc];

    key_round_step u_step (
        .i_cd    (w_step_in),
        .i_shift (w_step_shift),
        .o_cd    (w_step_out)
    );

`ifdef KEY_SCHED_DECRYPT_EN
    // Undo the left rotate of the round just emitted to step back one round.
    always_comb begin
        w_cd_right = {r_cd[HALF_W], r_cd[CD_W-1:HALF_W+1], r_cd[0], r_cd[HALF_W-1:1]};
        if (SHIFT_TABLE[r_round_idx] == 2'd2) begin
            w_cd_right = {r_cd[HALF_W+1:HALF_W], r_cd[CD_W-1:HALF_W+2],
                          r_cd[1:0], r_cd[HALF_W-1:2]};
        end
    end
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and datapath controls
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_handshake) begin
                    if (w_at_end) begin
                        w_finish     = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Key-schedule datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cd        <= '0;
            r_round_idx <= 4'd0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
`ifdef KEY_SCHED_DECRYPT_EN
            r_decrypt   <= 1'b0;
`endif
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_valid <= 1'b1;
`ifdef KEY_SCHED_DECRYPT_EN
                r_decrypt <= decrypt;
                if (decrypt) begin
                    // Full 28-bit rotation of all rounds returns to C0/D0,
                    // which is therefore already the round-16 pair.
                    r_cd        <= pc1_key;
                    r_round_idx <= c_idx_max;
                end else begin
                    r_cd        <= w_step_out;
                    r_round_idx <= 4'd0;
                end
`else
                r_cd        <= w_step_out;
                r_round_idx <= 4'd0;
`endif
            end else if (w_advance) begin
`ifdef KEY_SCHED_DECRYPT_EN
                if (r_decrypt) begin
                    r_cd        <= w_cd_right;
                    r_round_idx <= r_round_idx - 4'd1;
                end else begin
                    r_cd        <= w_step_out;
                    r_round_idx <= w_idx_inc;
                end
`else
                r_cd        <= w_step_out;
                r_round_idx <= w_idx_inc;
`endif
            end else if (w_finish) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign busy         = (r_state != ST_IDLE);
    assign subkey_valid = r_valid;
    assign subkey       = pc2(r_cd);
    assign round_idx    = r_round_idx;
    assign last         = r_valid & w_at_end;
    assign done         = r_done;

endmodule : round_key_generator
`default_nettype wire

// File: tb/tb_round_key_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_round_key_generator
// Description : Self-checking bench for round_key_generator. Expected subkeys
//               come from an independent DES key-schedule model and are
//               queued per schedule, then popped on each handshake.
//               Build option KEY_SCHED_DECRYPT_EN enables the decrypt test.
// Revision    : 1.0  initial release
// ============================================================================
module tb_round_key_generator;

    localparam logic [55:0] c_key_a = 56'hF0CCAAF556678F;
    localparam logic [55:0] c_key_b = 56'h123456789ABCDE;
    localparam logic [47:0] c_k1    = 48'h1B02EFFC7072;
    localparam logic [47:0] c_k16   = 48'hCB3D8B0E17F5;

    typedef struct {
        logic [47:0] key;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [55:0] pc1_key;
    logic        decrypt;
    logic        subkey_ready;
    logic        busy;
    logic        subkey_valid;
    logic [47:0] subkey;
    logic [3:0]  round_idx;
    logic        last;
    logic        done;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    int PC2_T [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                       23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                       41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                       44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    always #5 clk = ~clk;

    round_key_generator dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .pc1_key      (pc1_key),
`ifdef KEY_SCHED_DECRYPT_EN
        .decrypt      (decrypt),
`endif
        .subkey_ready (subkey_ready),
        .busy         (busy),
        .subkey_valid (subkey_valid),
        .subkey       (subkey),
        .round_idx    (round_idx),
        .last         (last),
        .done         (done)
    );

    // Reference: rotate C0/D0 by the cumulative shift count of round r,
    // then select bits with PC2 (1-based, MSB-first numbering).
    function automatic logic [47:0] model_key(input logic [55:0] pc1, input int round);
        int          nshift;
        logic [27:0] c;
        logic [27:0] d;
        logic [55:0] cd;
        logic [47:0] k;
        nshift = 0;
        for (int r = 1; r <= round; r++)
            nshift += (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
        c = pc1[55:28];
        d = pc1[27:0];
        for (int s = 0; s < nshift; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++)
            k[47-i] = cd[56 - PC2_T[i]];
        return k;
    endfunction

    task automatic push_schedule(input logic [55:0] key, input bit reverse);
        exp_t e;
        sb.delete();
        for (int n = 0; n < 16; n++) begin
            int r;
            r      = reverse ? 16 - n : n + 1;
            e.key  = model_key(key, r);
            e.idx  = 4'(r - 1);
            e.last = (n == 15);
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; pc1_key = c_key_a; decrypt = 1'b0; subkey_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, subkey_valid, last, done} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got busy/valid/last/done=%b expected 0000",
                     {busy, subkey_valid, last, done});
        end
        total++;
        if (subkey !== 48'h0 || round_idx !== 4'd0) begin
            bad++;
            $display("FAIL reset_data got subkey=%h idx=%0d expected 0/0", subkey, round_idx);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_encrypt();
        int got = 0;
        int budget = 100;
        push_schedule(c_key_a, 1'b0);
        start = 1'b1; pc1_key = c_key_a; subkey_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (subkey_valid !== 1'b1 || subkey !== c_k1 || round_idx !== 4'd0) begin
            bad++;
            $display("FAIL enc_k1_latency got valid=%b key=%h idx=%0d expected 1 %h 0",
                     subkey_valid, subkey, round_idx, c_k1);
        end
        while (got < 16 && budget > 0) begin
            if (subkey_valid === 1'b1) begin
                total++;
                if (subkey !== sb[0].key || round_idx !== sb[0].idx || last !== sb[0].last) begin
                    bad++;
                    $display("FAIL enc_key%0d got %h/%0d/%b expected %h/%0d/%b", got,
                             subkey, round_idx, last, sb[0].key, sb[0].idx, sb[0].last);
                end
                if (got == 15) begin
                    total++;
                    if (subkey !== c_k16 || last !== 1'b1) begin
                        bad++;
                        $display("FAIL enc_k16 got %h last=%b expected %h last=1", subkey, last, c_k16);
                    end
                end
                void'(sb.pop_front());
                got++;
            end
            budget--;
            @(negedge clk);
        end
        total++;
        if (got != 16) begin
            bad++;
            $display("FAIL enc_timeout got %0d keys expected 16", got);
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || subkey_valid !== 1'b0) begin
            bad++;
            $display("FAIL enc_done got done/busy/valid=%b%b%b expected 100", done, busy, subkey_valid);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL enc_done_pulse got done=%b expected 0", done);
        end
    endtask

    task automatic test_random_ready();
        int          got = 0;
        int          budget = 400;
        bit          stalled = 1'b0;
        logic [47:0] held_key;
        logic [3:0]  held_idx;
        push_schedule(c_key_a, 1'b0);
        start = 1'b1; pc1_key = c_key_a; subkey_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (got < 16 && budget > 0) begin
            if (stalled) begin
                total++;
                if (subkey_valid !== 1'b1 || subkey !== held_key || round_idx !== held_idx) begin
                    bad++;
                    $display("FAIL stall_hold got %b %h/%0d expected 1 %h/%0d",
                             subkey_valid, subkey, round_idx, held_key, held_idx);
                end
            end
            subkey_ready = 1'($urandom_range(0, 1));
            if (subkey_valid === 1'b1) begin
                total++;
                if (subkey !== sb[0].key || round_idx !== sb[0].idx || last !== sb[0].last) begin
                    bad++;
                    $display("FAIL rnd_key%0d got %h/%0d/%b expected %h/%0d/%b", got,
                             subkey, round_idx, last, sb[0].key, sb[0].idx, sb[0].last);
                end
                if (subkey_ready) begin
                    void'(sb.pop_front());
                    got++;
                end
            end
            stalled  = (subkey_valid === 1'b1) && !subkey_ready;
            held_key = subkey;
            held_idx = round_idx;
            budget--;
            @(negedge clk);
        end
        total++;
        if (got != 16 || done !== 1'b1) begin
            bad++;
            $display("FAIL rnd_complete got keys=%0d done=%b expected 16 1", got, done);
        end
        subkey_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int budget = 50;
        start = 1'b1; pc1_key = c_key_a; subkey_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (round_idx !== 4'd7 && budget > 0) begin
            budget--;
            @(negedge clk);
        end
        total++;
        if (round_idx !== 4'd7) begin
            bad++;
            $display("FAIL mid_reach got idx=%0d expected 7", round_idx);
        end
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, subkey_valid, last, done} !== 4'b0000 || subkey !== 48'h0 || round_idx !== 4'd0) begin
            bad++;
            $display("FAIL mid_reset got flags=%b key=%h idx=%0d expected 0000 0 0",
                     {busy, subkey_valid, last, done}, subkey, round_idx);
        end
        rst = 1'b0;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (subkey_valid !== 1'b1 || subkey !== c_k1 || round_idx !== 4'd0) begin
            bad++;
            $display("FAIL mid_restart got %b %h/%0d expected 1 %h/0", subkey_valid, subkey, round_idx, c_k1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_start_held();
        int got = 0;
        int budget = 100;
        push_schedule(c_key_a, 1'b0);
        start = 1'b1; pc1_key = c_key_a; subkey_ready = 1'b1;
        @(negedge clk);
        pc1_key = c_key_b;
        while (got < 16 && budget > 0) begin
            if (subkey_valid === 1'b1) begin
                total++;
                if (subkey !== sb[0].key || round_idx !== sb[0].idx || last !== sb[0].last) begin
                    bad++;
                    $display("FAIL held_key%0d got %h/%0d/%b expected %h/%0d/%b", got,
                             subkey, round_idx, last, sb[0].key, sb[0].idx, sb[0].last);
                end
                void'(sb.pop_front());
                got++;
            end
            budget--;
            @(negedge clk);
        end
        total++;
        if (got != 16 || busy !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL held_idle got keys=%0d busy=%b done=%b expected 16 0 1", got, busy, done);
        end
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

`ifdef KEY_SCHED_DECRYPT_EN
    task automatic test_decrypt();
        int got = 0;
        int budget = 100;
        push_schedule(c_key_a, 1'b1);
        start = 1'b1; pc1_key = c_key_a; decrypt = 1'b1; subkey_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; decrypt = 1'b0;
        total++;
        if (subkey !== c_k16 || round_idx !== 4'd15) begin
            bad++;
            $display("FAIL dec_first got %h/%0d expected %h/15", subkey, round_idx, c_k16);
        end
        while (got < 16 && budget > 0) begin
            if (subkey_valid === 1'b1) begin
                total++;
                if (subkey !== sb[0].key || round_idx !== sb[0].idx || last !== sb[0].last) begin
                    bad++;
                    $display("FAIL dec_key%0d got %h/%0d/%b expected %h/%0d/%b", got,
                             subkey, round_idx, last, sb[0].key, sb[0].idx, sb[0].last);
                end
                if (got == 15) begin
                    total++;
                    if (subkey !== c_k1 || round_idx !== 4'd0 || last !== 1'b1) begin
                        bad++;
                        $display("FAIL dec_last got %h/%0d/%b expected %h/0/1", subkey, round_idx, last, c_k1);
                    end
                end
                void'(sb.pop_front());
                got++;
            end
            budget--;
            @(negedge clk);
        end
        total++;
        if (got != 16 || done !== 1'b1) begin
            bad++;
            $display("FAIL dec_complete got keys=%0d done=%b expected 16 1", got, done);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_encrypt();
        test_random_ready();
        test_reset_mid();
        test_start_held();
`ifdef KEY_SCHED_DECRYPT_EN
        test_decrypt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_round_key_generator
`default_nettype wire
